// File: rtl/calc_key_sequencer.sv
// -----------------------------------------------------------------------------
// calc_key_sequencer
//   Keypad front end of the 3-bit sign-magnitude calculator. One key event is
//   taken per valid/ready handshake and used to build operand A, the operation
//   select and operand B. On equals the registered operands are held steady
//   while the combinational ALU settles for EXEC_WAIT cycles. The ALU answer
//   and its flags are then captured and held. A result whose magnitude fits
//   in two bits can seed operand A of the next operation (chaining).
//
// Ports
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   key_valid/ready    key handshake; ready is low while the ALU settles
//   key_code[3:0]      0-3 digit, 4 sign, 8-11 op (mul/mod/add/sub),
//                      12 equals, 13 clear, others illegal
//   alu_a/alu_b[2:0]   operands to the ALU {sign, magnitude[1:0]}
//   alu_s[1:0]         operation select to the ALU
//   alu_answer[4:0]    ALU result {sign, magnitude[3:0]}
//   alu_dz, alu_z      ALU divide-by-zero and zero flags
//   result[4:0]        captured answer
//   result_valid       one-cycle pulse on capture
//   result_zero        captured zero flag
//   dz_err             captured divide-by-zero (mod only)
//   key_err            one-cycle pulse on an illegal or out-of-context key
//   busy               high while waiting for the ALU to settle
// -----------------------------------------------------------------------------
module calc_key_sequencer #(
   parameter int unsigned EXEC_WAIT = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   output logic       key_ready,
   output logic [2:0] alu_a,
   output logic [2:0] alu_b,
   output logic [1:0] alu_s,
   input  logic [4:0] alu_answer,
   input  logic       alu_dz,
   input  logic       alu_z,
   output logic [4:0] result,
   output logic       result_valid,
   output logic       result_zero,
   output logic       dz_err,
   output logic       key_err,
   output logic       busy
);

   typedef enum logic [1:0] {
      ST_ENTER_A = 2'd0,
      ST_ENTER_B = 2'd1,
      ST_EXEC    = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   localparam logic [3:0] LAST_CNT = 4'(EXEC_WAIT - 1);

   state_t     state_q;
   logic       sign_a_q;
   logic [1:0] mag_a_q;
   logic       sign_b_q;
   logic [1:0] mag_b_q;
   logic       b_entered_q;
   logic [1:0] alu_s_q;
   logic [3:0] cnt_q;
   logic [4:0] result_q;
   logic       result_valid_q;
   logic       result_zero_q;
   logic       dz_err_q;
   logic       key_err_q;
   logic       key_ready_q;
   logic       busy_q;

   logic       key_acc_s;
   logic       is_digit_s;
   logic       is_sign_s;
   logic       is_op_s;
   logic       is_eq_s;
   logic       is_clr_s;
   logic       is_ill_s;

   assign key_acc_s = key_valid & key_ready_q;

   // Key code classification.
   always_comb begin
      is_digit_s = 1'b0;
      is_sign_s  = 1'b0;
      is_op_s    = 1'b0;
      is_eq_s    = 1'b0;
      is_clr_s   = 1'b0;
      is_ill_s   = 1'b0;
      case (key_code)
         4'd0, 4'd1, 4'd2, 4'd3:   is_digit_s = 1'b1;
         4'd4:                     is_sign_s  = 1'b1;
         4'd8, 4'd9, 4'd10, 4'd11: is_op_s    = 1'b1;
         4'd12:                    is_eq_s    = 1'b1;
         4'd13:                    is_clr_s   = 1'b1;
         default:                  is_ill_s   = 1'b1;
      endcase
   end

   // Sequencer: key handling, settle counter and result capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_ENTER_A;
         sign_a_q       <= 1'b0;
         mag_a_q        <= 2'd0;
         sign_b_q       <= 1'b0;
         mag_b_q        <= 2'd0;
         b_entered_q    <= 1'b0;
         alu_s_q        <= 2'd0;
         cnt_q          <= 4'd0;
         result_q       <= 5'd0;
         result_valid_q <= 1'b0;
         result_zero_q  <= 1'b0;
         dz_err_q       <= 1'b0;
         key_err_q      <= 1'b0;
         key_ready_q    <= 1'b1;
         busy_q         <= 1'b0;
      end else begin
         result_valid_q <= 1'b0;
         key_err_q      <= 1'b0;
         if (state_q == ST_EXEC) begin
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == LAST_CNT) begin
               result_q       <= alu_answer;
               result_zero_q  <= alu_z;
               dz_err_q       <= alu_dz & (alu_s_q == 2'b01);
               result_valid_q <= 1'b1;
               busy_q         <= 1'b0;
               key_ready_q    <= 1'b1;
               state_q        <= ST_DONE;
            end else begin
               busy_q <= 1'b1;
            end
         end else if (key_acc_s) begin
            if (is_clr_s) begin
               state_q       <= ST_ENTER_A;
               sign_a_q      <= 1'b0;
               mag_a_q       <= 2'd0;
               sign_b_q      <= 1'b0;
               mag_b_q       <= 2'd0;
               b_entered_q   <= 1'b0;
               alu_s_q       <= 2'd0;
               cnt_q         <= 4'd0;
               result_q      <= 5'd0;
               result_zero_q <= 1'b0;
               dz_err_q      <= 1'b0;
            end else if (is_ill_s) begin
               key_err_q <= 1'b1;
            end else begin
               case (state_q)
                  ST_ENTER_A: begin
                     if (is_digit_s) begin
                        mag_a_q <= key_code[1:0];
                     end else if (is_sign_s) begin
                        sign_a_q <= ~sign_a_q;
                     end else if (is_op_s) begin
                        alu_s_q     <= key_code[1:0];
                        mag_b_q     <= 2'd0;
                        sign_b_q    <= 1'b0;
                        b_entered_q <= 1'b0;
                        state_q     <= ST_ENTER_B;
                     end else begin
                        key_err_q <= 1'b1;
                     end
                  end
                  ST_ENTER_B: begin
                     if (is_digit_s) begin
                        mag_b_q     <= key_code[1:0];
                        b_entered_q <= 1'b1;
                     end else if (is_sign_s) begin
                        sign_b_q <= ~sign_b_q;
                     end else if (is_op_s) begin
                        // The operator may be changed until B has a digit.
                        if (b_entered_q) begin
                           key_err_q <= 1'b1;
                        end else begin
                           alu_s_q <= key_code[1:0];
                        end
                     end else begin
                        cnt_q       <= 4'd0;
                        busy_q      <= 1'b1;
                        key_ready_q <= 1'b0;
                        state_q     <= ST_EXEC;
                     end
                  end
                  ST_DONE: begin
                     if (is_digit_s) begin
                        sign_a_q      <= 1'b0;
                        mag_a_q       <= key_code[1:0];
                        dz_err_q      <= 1'b0;
                        result_zero_q <= 1'b0;
                        state_q       <= ST_ENTER_A;
                     end else if (is_op_s && (result_q[3:2] == 2'b00)) begin
                        // Chain: the previous result fits a 2-bit operand.
                        sign_a_q    <= result_q[4];
                        mag_a_q     <= result_q[1:0];
                        alu_s_q     <= key_code[1:0];
                        mag_b_q     <= 2'd0;
                        sign_b_q    <= 1'b0;
                        b_entered_q <= 1'b0;
                        state_q     <= ST_ENTER_B;
                     end else begin
                        key_err_q <= 1'b1;
                     end
                  end
                  default: begin
                     state_q <= ST_ENTER_A;
                  end
               endcase
            end
         end else begin
            busy_q <= 1'b0;
         end
      end
   end

   // Negative zero is suppressed on the operand outputs.
   assign alu_a        = {sign_a_q & (mag_a_q != 2'd0), mag_a_q};
   assign alu_b        = {sign_b_q & (mag_b_q != 2'd0), mag_b_q};
   assign alu_s        = alu_s_q;
   assign key_ready    = key_ready_q;
   assign result       = result_q;
   assign result_valid = result_valid_q;
   assign result_zero  = result_zero_q;
   assign dz_err       = dz_err_q;
   assign key_err      = key_err_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_calc_key_sequencer.sv
module tb_calc_key_sequencer;

   localparam int EW = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       key_valid = 1'b0;
   logic [3:0] key_code = 4'd0;
   logic       key_ready;
   logic [2:0] alu_a, alu_b;
   logic [1:0] alu_s;
   logic [4:0] alu_answer;
   logic       alu_dz, alu_z;
   logic [4:0] result;
   logic       result_valid, result_zero, dz_err, key_err, busy;

   int n_cmp = 0;
   int n_mis = 0;

   // reference model state
   int         m_st;   // 0 enter A, 1 enter B, 3 done
   bit         m_sa, m_sb, m_be, m_rz, m_dz;
   int         m_ma, m_mb;
   logic [1:0] m_s;
   logic [4:0] m_res;

   calc_key_sequencer #(.EXEC_WAIT(EW)) dut (
      .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
      .key_ready(key_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
      .alu_answer(alu_answer), .alu_dz(alu_dz), .alu_z(alu_z),
      .result(result), .result_valid(result_valid), .result_zero(result_zero),
      .dz_err(dz_err), .key_err(key_err), .busy(busy)
   );

   always #5 clk = ~clk;

   // Sign-magnitude ALU: returns {dz, z, sign, mag[3:0]}.
   function automatic logic [6:0] alu_fn(input logic [2:0] a, input logic [2:0] b,
                                         input logic [1:0] s);
      int va, vb, r, mag;
      logic dz;
      logic [3:0] m4;
      va = a[2] ? -int'(a[1:0]) : int'(a[1:0]);
      vb = b[2] ? -int'(b[1:0]) : int'(b[1:0]);
      dz = 1'b0;
      case (s)
         2'b00: r = va * vb;
         2'b01: begin
            if (b[1:0] == 2'd0) begin
               dz = 1'b1;
               r  = 0;
            end else begin
               r = int'(a[1:0]) % int'(b[1:0]);
               if (a[2]) r = -r;
            end
         end
         2'b10: r = va + vb;
         default: r = va - vb;
      endcase
      mag = (r < 0) ? -r : r;
      m4  = 4'(mag);
      return {dz, (r == 0), (r < 0), m4};
   endfunction

   // ALU environment driven from the DUT operand outputs.
   always_comb begin
      logic [6:0] t;
      t = alu_fn(alu_a, alu_b, alu_s);
      alu_dz     = t[6];
      alu_z      = t[5];
      alu_answer = t[4:0];
   end

   function automatic logic [2:0] op_vec(input bit sg, input int mg);
      logic [1:0] m2;
      m2 = 2'(mg);
      return {sg && (mg != 0), m2};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_st = 0; m_sa = 0; m_sb = 0; m_be = 0; m_rz = 0; m_dz = 0;
      m_ma = 0; m_mb = 0; m_s = 2'd0; m_res = 5'd0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".alu_a"}, alu_a, 0);
      chk({tag, ".alu_b"}, alu_b, 0);
      chk({tag, ".alu_s"}, alu_s, 0);
      chk({tag, ".result"}, result, 0);
      chk({tag, ".rv"}, result_valid, 0);
      chk({tag, ".rz"}, result_zero, 0);
      chk({tag, ".dz"}, dz_err, 0);
      chk({tag, ".kerr"}, key_err, 0);
      chk({tag, ".busy"}, busy, 0);
      chk({tag, ".ready"}, key_ready, 1);
   endtask

   task automatic chk_state(input string tag);
      chk({tag, ".alu_a"}, alu_a, op_vec(m_sa, m_ma));
      chk({tag, ".alu_b"}, alu_b, op_vec(m_sb, m_mb));
      chk({tag, ".alu_s"}, alu_s, m_s);
      chk({tag, ".result"}, result, m_res);
      chk({tag, ".rz"}, result_zero, m_rz);
      chk({tag, ".dz"}, dz_err, m_dz);
   endtask

   // Present one key; if it is equals from ENTER_B, follow the execution.
   task automatic key(input logic [3:0] c, input bit hold = 1'b0);
      bit exp_err, go;
      logic [6:0] r;
      chk("ready_before", key_ready, 1);
      key_valid = 1'b1;
      key_code  = c;
      @(posedge clk); #1;
      key_valid = 1'b0;
      exp_err = 0;
      go = 0;
      if (c == 4'd13) m_reset();
      else if (c inside {[4'd5:4'd7], 4'd14, 4'd15}) exp_err = 1;
      else if (m_st == 0) begin
         if (c <= 4'd3) m_ma = int'(c);
         else if (c == 4'd4) m_sa = !m_sa;
         else if (c <= 4'd11) begin
            m_s = c[1:0]; m_mb = 0; m_sb = 0; m_be = 0; m_st = 1;
         end else exp_err = 1;
      end else if (m_st == 1) begin
         if (c <= 4'd3) begin m_mb = int'(c); m_be = 1; end
         else if (c == 4'd4) m_sb = !m_sb;
         else if (c <= 4'd11) begin
            if (m_be) exp_err = 1;
            else m_s = c[1:0];
         end else go = 1;
      end else begin
         if (c <= 4'd3) begin
            m_sa = 0; m_ma = int'(c); m_dz = 0; m_rz = 0; m_st = 0;
         end else if (c >= 4'd8 && c <= 4'd11 && m_res[3:2] == 2'b00) begin
            m_sa = m_res[4]; m_ma = int'(m_res[1:0]); m_s = c[1:0];
            m_mb = 0; m_sb = 0; m_be = 0; m_st = 1;
         end else exp_err = 1;
      end
      chk("key_err", key_err, exp_err);
      chk("busy", busy, go);
      chk("ready_after", key_ready, !go);
      chk("rv_after_key", result_valid, 0);
      chk_state("key");
      if (go) begin
         r = alu_fn(op_vec(m_sa, m_ma), op_vec(m_sb, m_mb), m_s);
         if (hold) begin
            key_valid = 1'b1;
            key_code  = 4'd1;
         end
         for (int i = 1; i <= EW; i++) begin
            @(posedge clk); #1;
            if (i < EW) begin
               chk("exec_busy", busy, 1);
               chk("exec_rv", result_valid, 0);
               chk("exec_ready", key_ready, 0);
            end
         end
         key_valid = 1'b0;
         m_res = r[4:0];
         m_rz  = r[5];
         m_dz  = r[6] && (m_s == 2'b01);
         m_st  = 3;
         chk("cap_rv", result_valid, 1);
         chk("cap_busy", busy, 0);
         chk("cap_ready", key_ready, 1);
         chk("cap_kerr", key_err, 0);
         chk_state("cap");
         @(posedge clk); #1;
         chk("rv_pulse_end", result_valid, 0);
         chk_state("post_cap");
      end
   endtask

   initial begin
      m_reset();
      repeat (3) @(posedge clk);
      #1;
      chk_reset("reset");
      rst = 1'b0;
      @(posedge clk); #1;
      chk_reset("after_release");

      // multiply with negative A
      key(4'd2); key(4'd4); key(4'd8); key(4'd3);
      chk("neg_a", alu_a, 3'b110);
      key(4'd12);
      chk("mul_result", result, 5'b10110);
      // mod by zero, then a clean add
      key(4'd3); key(4'd9); key(4'd12);
      chk("dz_set", dz_err, 1);
      key(4'd3); key(4'd10); key(4'd12);
      chk("dz_clear", dz_err, 0);
      // no negative zero
      key(4'd13); key(4'd4); key(4'd0); key(4'd10); key(4'd4); key(4'd0);
      chk("negz_a", alu_a, 3'b000);
      chk("negz_b", alu_b, 3'b000);
      key(4'd12);
      chk("zero_flag", result_zero, 1);
      // chaining
      key(4'd1); key(4'd10); key(4'd1); key(4'd12);
      chk("chain1", result, 5'b00010);
      key(4'd10); key(4'd3);
      chk("chain_a", alu_a, 3'b010);
      key(4'd12);
      chk("chain2", result, 5'b00101);
      key(4'd11);
      chk("chain_too_big", key_err, 1);
      // context / illegal keys, held key during execution
      key(4'd13); key(4'd2); key(4'd7); key(4'd12);
      key(4'd8); key(4'd9);
      chk("op_replace", alu_s, 2'b01);
      key(4'd2); key(4'd12, 1'b1);
      chk("held_not_taken", alu_a, 3'b010);

      // reset during the second execution cycle
      key(4'd13); key(4'd1); key(4'd10); key(4'd1);
      key_valid = 1'b1; key_code = 4'd12;
      @(posedge clk); #1;
      key_valid = 1'b0;
      chk("rst_exec_busy", busy, 1);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk_reset("rst_mid_exec");
      @(posedge clk); #1;
      chk("rst_no_rv", result_valid, 0);
      rst = 1'b0;
      m_reset();
      @(posedge clk); #1;
      chk_reset("rst_release");

      // randomized key stream
      for (int n = 0; n < 400; n++) begin
         key(4'($urandom_range(0, 15)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/calc_key_sequencer.md
Name: calc_key_sequencer

Overview:
- Keypad-side front end of the 3-bit sign-magnitude calculator.
- Accepts one key event per handshake and assembles operand A, the operation select and operand B.
- Drives these into the combinational ALU, waits a fixed settle time, then captures and holds the 5-bit sign-magnitude answer and its flags.
- Supports chaining: the next operation can start from the previous result.

Parameters:
- EXEC_WAIT, 2, number of cycles between entering EXEC and capturing the ALU outputs. Legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- key_valid  in  1  key event present.
- key_code  in  4  key code:
  - 0-3: magnitude digit.
  - 4: sign toggle.
  - 8: mul (S=00).
  - 9: mod (S=01).
  - 10: add (S=10).
  - 11: sub (S=11).
  - 12: equals.
  - 13: clear.
  - 5-7, 14, 15: illegal.
- key_ready  out  1  key accepted on a clk edge where key_valid and key_ready are both 1.
- alu_a  out  3  operand A to the ALU: bit2 sign, bits 1:0 magnitude.
- alu_b  out  3  operand B to the ALU, same format.
- alu_s  out  2  operation select to the ALU.
- alu_answer  in  5  ALU result: bit4 sign, bits 3:0 magnitude.
- alu_dz  in  1  ALU divide-by-zero flag.
- alu_z  in  1  ALU zero flag.
- result  out  5  captured answer, held until the next capture or clear.
- result_valid  out  1  one-cycle pulse on capture.
- result_zero  out  1  captured alu_z.
- dz_err  out  1  captured alu_dz AND (alu_s==01).
- key_err  out  1  one-cycle pulse when an accepted key is illegal or out of context.
- busy  out  1  high in EXEC.

Behaviour:
- Reset (async, immediate), all outputs to these values:
  - state=ENTER_A; sign/magnitude registers = 0.
  - alu_a=000, alu_b=000, alu_s=00.
  - result=00000; result_valid, result_zero, dz_err, key_err, busy = 0; key_ready=1.
- Operand outputs:
  - alu_a = {sign_a & (mag_a!=0), mag_a}; alu_b is formed the same way.
  - Negative zero is never driven.
  - Operands are registered, so they are stable during EXEC.
- key_ready = 1 in ENTER_A, ENTER_B and DONE; 0 in EXEC. Keys presented in EXEC are not consumed.
- ENTER_A:
  - Digit: mag_a=digit (the last digit wins).
  - Sign: toggle sign_a.
  - Op: alu_s=op, mag_b=0, sign_b=0, b_entered=0, then go to ENTER_B.
  - Equals: key_err, no state change.
- ENTER_B:
  - Digit: mag_b=digit, b_entered=1.
  - Sign: toggle sign_b.
  - Op with b_entered=0: replaces alu_s.
  - Op with b_entered=1: key_err.
  - Equals: go to EXEC with counter=0. A missing B digit means B=000.
- EXEC:
  - busy=1 and the counter increments each cycle.
  - On the edge where counter==EXEC_WAIT-1: result<=alu_answer, result_zero<=alu_z, dz_err<=alu_dz&(alu_s==01). result_valid is high for the following cycle only; go to DONE.
  - Capture latency: the capture edge is the EXEC_WAIT-th clk edge after the equals acceptance edge; result_valid is asserted for the next cycle.
- DONE:
  - Digit: start a new calculation; sign_a=0, mag_a=digit, clear dz_err and result_zero, go to ENTER_A.
  - Op with result[3:2]==00 (chain): sign_a=result[4], mag_a=result[1:0], alu_s=op, go to ENTER_B.
  - Op with result magnitude >3: key_err, remain in DONE.
  - Sign or equals: key_err.
- Clear (13): accepted in any key_ready state. Returns every register to its reset value except key_err, which stays 0.
- Illegal codes:
  - key_err is pulsed for one cycle; no other register changes.
  - key_err and result_valid are never both high in the same cycle.
- Reset asserted mid-EXEC:
  - Immediate return to reset values; no result_valid pulse is produced.
  - After release, the block waits in ENTER_A.

Test Plan:
- Keys 2, 4, 8, 3, 12 → alu_a=110, alu_s=00, alu_b=011; with the ALU model, result=10110, one result_valid pulse, dz_err=0.
- Keys 3, 9, 12 → alu_b=000; ALU asserts alu_dz, so dz_err=1 after capture. Then keys 3, 10, 12 → dz_err=0.
- Keys 4, 0, 10, 4, 0, 12 → alu_a=000 and alu_b=000 (no negative zero); result_zero=1, result magnitude 0000.
- Chain: 1, 10, 1, 12 gives result=00010; then 10, 3, 12 → alu_a=010, alu_b=011, result=00101. A further 11 key (magnitude 5 >3) → key_err pulse, state stays DONE.
- Context and illegal keys:
  - key_code=7 in ENTER_A → key_err pulse, alu_a unchanged.
  - 12 in ENTER_A → key_err.
  - 8 then 9 before any B digit → alu_s=01, no key_err.
  - key_valid held during EXEC → key_ready=0, key not consumed.
- Assert rst during the second EXEC cycle (EXEC_WAIT=2) → all outputs at reset values in the same cycle; no result_valid. After release, ENTER_A with key_ready=1.
